uart_tx_arbiter: RTL

Round-robin scheduler that shares one `uart_tx` transmitter among `NUM_REQ` on-chip byte producers. Each requester presents a byte with a level request. The arbiter selects one, pulses the transmitter's start control, then holds off all other requesters until the transmitter reports completion. It sits between the requesting engines and `uart_tx`, mirroring the `uart_rx` path on the receive side.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to let a requester hold the transmitter across a multi-byte packet.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_byte,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   tx_ctrl,
  output logic [7:0]             tx_byte,
  input  logic                   tx_busy,
  output logic                   arb_busy,
  output logic                   arb_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [IdxW-1:0] rr_idx;
  logic            rr_found;
  logic            lock_hold;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  // The lock always belongs to the last launched requester, so last_q doubles as its owner.
  assign lock_hold = lock_q & req[last_q];
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
  assign lock_hold       = 1'b0;
`endif

  // Scan from last+1 so the most recent winner has lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!rr_found && req[IdxW'((int'(last_q) + off) % NUM_REQ)]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'((int'(last_q) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    ack       = '0;
    tx_ctrl   = 1'b0;
    arb_err   = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d    = lock_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (lock_hold) begin
          idx_d     = last_q;
          tx_byte_d = req_byte[8*last_q +: 8];
          state_d   = StLaunch;
        end else if (rr_found) begin
          idx_d     = rr_idx;
          tx_byte_d = req_byte[8*rr_idx +: 8];
          state_d   = StLaunch;
        end
`ifdef UART_ARB_LOCK_EN
        if (lock_q && !req[last_q]) lock_d = 1'b0;
`endif
      end
      StLaunch: begin
        tx_ctrl    = 1'b1;
        ack[idx_q] = 1'b1;
        last_d     = idx_q;
        cnt_d      = '0;
        state_d    = StWaitBusy;
`ifdef UART_ARB_LOCK_EN
        lock_d     = req_lock[idx_q];
`endif
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
          // Byte was already acked, so a missed start simply drops it.
          arb_err = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_q    <= IdxW'(NUM_REQ - 1);
      cnt_q     <= '0;
      tx_byte_q <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
`ifdef UART_ARB_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  assign tx_byte  = tx_byte_q;
  assign arb_busy = (state_q != StIdle);

endmodule
